// File: rtl/spi_target_apb.sv
`default_nettype none
// spi_target_apb: mode-0 SPI target with a zero-wait APB3 register interface, all in the PCLK domain.
// Optional macro SPI_TGT_IRQ_EN adds the IER register and the interrupt_spi logic.
module spi_target_apb #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        sclk_spi,
    input  logic        cs_spi,
    input  logic        mosi_spi,
    output logic        miso_spi,
    output logic        miso_oe,
    output logic        interrupt_spi
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] vld_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   armed;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] tx_hold;
    logic [7:0] rx_data;
    logic       tx_full;
    logic       rx_avail;
    logic       overrun;
    logic       underrun;
    logic [1:0] ier;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic access, addr_ok;
    logic [1:0] reg_sel;
    logic wr_tx, rd_rx, wr_st;
    logic tx_load, byte_done;
    logic [7:0] tx_next, rx_byte;
    logic [31:0] status_word;

    assign PREADY = 1'b1;

    // cs resets high so reset never looks like a frame start; armed additionally
    // requires a genuinely observed high cs before the first falling edge counts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_spi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_spi};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_spi};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            armed     <= armed | (vld_sync[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;

    assign access  = PSEL & PENABLE;
    assign addr_ok = (PADDR[11:4] == 8'h00);
    assign reg_sel = PADDR[3:2];
    assign wr_tx   = access & addr_ok & PWRITE  & (reg_sel == 2'd0);
    assign rd_rx   = access & addr_ok & ~PWRITE & (reg_sel == 2'd1);
    assign wr_st   = access & addr_ok & PWRITE  & (reg_sel == 2'd2);

    assign tx_next   = tx_full ? tx_hold : 8'hFF;
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign tx_load   = ((state == ST_IDLE) & cs_fall) |
                       ((state == ST_SHIFT) & ~cs_rise & sclk_fall & (bit_cnt == 3'd0));
    assign byte_done = (state == ST_SHIFT) & ~cs_rise & sclk_rise & (bit_cnt == 3'd7);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            miso_oe  <= 1'b0;
            miso_spi <= 1'b0;
        end else begin
            miso_spi <= ((state == ST_SHIFT) & ~cs_rise) ? tx_shift[7] : 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state    <= ST_SHIFT;
                        tx_shift <= tx_next;
                        bit_cnt  <= 3'd0;
                        miso_oe  <= 1'b1;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state   <= ST_IDLE;
                        bit_cnt <= 3'd0;
                        miso_oe <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end else if (sclk_fall) begin
                        if (bit_cnt != 3'd0) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end else begin
                            tx_shift <= tx_next;
                        end
                    end
                end
            endcase
        end
    end

    // Event sets are ordered after the W1C/read clears so a coincident event wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_hold  <= 8'h00;
            tx_full  <= 1'b0;
            rx_data  <= 8'h00;
            rx_avail <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_tx) begin
                tx_hold <= PWDATA[7:0];
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end

            if (wr_st & PWDATA[4]) begin
                underrun <= 1'b0;
            end
            if (tx_load & ~tx_full) begin
                underrun <= 1'b1;
            end

            if (wr_st & PWDATA[2]) begin
                overrun <= 1'b0;
            end
            if (byte_done & rx_avail & ~rd_rx) begin
                overrun <= 1'b1;
            end

            if (rd_rx) begin
                rx_avail <= 1'b0;
            end
            if (byte_done & (~rx_avail | rd_rx)) begin
                rx_data  <= rx_byte;
                rx_avail <= 1'b1;
            end
        end
    end

`ifdef SPI_TGT_IRQ_EN
    logic wr_ier;
    assign wr_ier = access & addr_ok & PWRITE & (reg_sel == 2'd3);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ier           <= 2'b00;
            interrupt_spi <= 1'b0;
        end else begin
            if (wr_ier) begin
                ier <= PWDATA[1:0];
            end
            interrupt_spi <= (ier[0] & rx_avail) | (ier[1] & (overrun | underrun));
        end
    end
`else
    assign ier           = 2'b00;
    assign interrupt_spi = 1'b0;
`endif

    assign status_word = {27'd0, underrun, ~cs_s, overrun, tx_full, rx_avail};

    always_comb begin
        PRDATA  = 32'd0;
        PSLVERR = 1'b0;
        if (access) begin
            if (!addr_ok) begin
                PSLVERR = 1'b1;
            end else if (!PWRITE) begin
                case (reg_sel)
                    2'd1:    PRDATA = {24'd0, rx_data};
                    2'd2:    PRDATA = status_word;
                    2'd3:    PRDATA = {30'd0, ier};
                    default: PRDATA = 32'd0;
                endcase
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, PADDR[31:12], PADDR[1:0], PWDATA[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_spi_target_apb.sv
`default_nettype none
// tb_spi_target_apb: bench acting as SPI master and APB host, checked against a transaction-level model.
module tb_spi_target_apb;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] PADDR = 32'd0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        sclk_spi = 1'b0;
    logic        cs_spi = 1'b1;
    logic        mosi_spi = 1'b0;
    logic        miso_spi;
    logic        miso_oe;
    logic        interrupt_spi;

    spi_target_apb #(.SYNC_STAGES(SYNC)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .sclk_spi(sclk_spi), .cs_spi(cs_spi), .mosi_spi(mosi_spi), .miso_spi(miso_spi),
        .miso_oe(miso_oe), .interrupt_spi(interrupt_spi)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the register state.
    bit [7:0] m_hold, m_rx;
    bit       m_full, m_avail, m_ovr, m_und;
    bit [1:0] m_ier;
    bit       settled = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_irq();
`ifdef SPI_TGT_IRQ_EN
        return (m_ier[0] & m_avail) | (m_ier[1] & (m_ovr | m_und));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_ier_rd();
`ifdef SPI_TGT_IRQ_EN
        return {30'd0, m_ier};
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] m_status();
        return {27'd0, m_und, 1'b0, m_ovr, m_full, m_avail};
    endfunction

    task automatic m_reset();
        m_hold = 0; m_rx = 0; m_full = 0; m_avail = 0; m_ovr = 0; m_und = 0; m_ier = 0;
    endtask

    always @(negedge PCLK) begin
        if (settled) begin
            check("irq_level", {31'd0, interrupt_spi}, {31'd0, m_irq()});
            check("oe_idle", {31'd0, miso_oe}, 32'd0);
            check("pready", {31'd0, PREADY}, 32'd1);
        end
    end

    task automatic settle();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        settled = 1'b1;
    endtask

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        settled = 1'b0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        logic [31:0] rd; logic err;
        apb(1'b1, 32'h0, {24'hABCDEF, b}, rd, err);
        check("tx_wr_err", {31'd0, err}, 32'd0);
        m_hold = b; m_full = 1'b1;
        settle();
    endtask

    task automatic rx_read(output logic [31:0] rd);
        logic err;
        apb(1'b0, 32'h4, 32'h0, rd, err);
        check("rxdata", rd, {24'd0, m_rx});
        check("rx_rd_err", {31'd0, err}, 32'd0);
        m_avail = 1'b0;
        settle();
    endtask

    task automatic st_read(output logic [31:0] rd);
        logic err;
        apb(1'b0, 32'h8, 32'h0, rd, err);
        check("status", rd, m_status());
        settle();
    endtask

    task automatic st_w1c(input logic [31:0] v);
        logic [31:0] rd; logic err;
        apb(1'b1, 32'h8, v, rd, err);
        if (v[2]) m_ovr = 1'b0;
        if (v[4]) m_und = 1'b0;
        settle();
    endtask

    task automatic ier_write(input logic [1:0] v);
        logic [31:0] rd; logic err;
        apb(1'b1, 32'hC, {30'd0, v}, rd, err);
        m_ier = v;
        apb(1'b0, 32'hC, 32'h0, rd, err);
        check("ier_rd", rd, m_ier_rd());
        settle();
    endtask

    // Master-side frame of nbits bits taken MSB-first from mdata[23:0].
    task automatic frame(input int nbits, input logic [23:0] mdata, output logic [7:0] got0);
        bit [7:0] txb[4];
        int nfull;
        logic [7:0] sh;
        settled = 1'b0;
        nfull = nbits / 8;
        for (int j = 0; j <= nfull; j++) begin
            txb[j] = m_full ? m_hold : 8'hFF;
            if (!m_full) m_und = 1'b1;
            m_full = 1'b0;
        end
        for (int j = 0; j < nfull; j++) begin
            if (!m_avail) begin
                m_rx = mdata[23-8*j -: 8];
                m_avail = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        got0 = 8'h00;
        sh = 8'h00;
        @(negedge PCLK);
        cs_spi = 1'b0;
        repeat (8) @(negedge PCLK);
        for (int i = 0; i < nbits; i++) begin
            mosi_spi = mdata[23-i];
            repeat (HALF) @(negedge PCLK);
            sh = {sh[6:0], miso_spi};
            check("oe_active", {31'd0, miso_oe}, 32'd1);
            sclk_spi = 1'b1;
            repeat (HALF) @(negedge PCLK);
            sclk_spi = 1'b0;
            if (i % 8 == 7) begin
                check("miso_byte", {24'd0, sh}, {24'd0, txb[i/8]});
                if (i == 7) got0 = sh;
            end
        end
        repeat (HALF) @(negedge PCLK);
        cs_spi = 1'b1;
        repeat (SYNC + 2) @(negedge PCLK);
        check("oe_release", {31'd0, miso_oe}, 32'd0);
        check("miso_release", {31'd0, miso_spi}, 32'd0);
        repeat (4) @(negedge PCLK);
        settle();
    endtask

    initial begin
        #2ms;
        errors++;
        $display("FAIL timeout simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  got;

        m_reset();
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        check("rst_miso", {31'd0, miso_spi}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_irq", {31'd0, interrupt_spi}, 32'd0);
        repeat (4) @(negedge PCLK);
        settle();
        st_read(rd);
        check("rst_status_lit", rd, 32'h0);

        // Loaded byte goes out while a byte comes in; trailing reload underruns.
        tx_write(8'hA5);
        frame(8, 24'h3C0000, got);
        check("tc1_miso_lit", {24'd0, got}, 32'hA5);
        st_read(rd);
        check("tc1_status_lit", rd, 32'h11);
        rx_read(rd);
        check("tc1_rx_lit", rd, 32'h3C);
        st_read(rd);
        check("tc1_status2_lit", rd, 32'h10);
        st_w1c(32'h10);
        st_read(rd);
        check("tc1_w1c_lit", rd, 32'h0);

        // Empty holding register.
        frame(8, 24'h550000, got);
        check("tc2_miso_lit", {24'd0, got}, 32'hFF);
        st_read(rd);
        check("tc2_status_lit", rd, 32'h11);
        st_w1c(32'h10);
        st_read(rd);
        check("tc2_w1c_lit", rd, 32'h01);
        rx_read(rd);

        // Two bytes with no read between: overrun keeps the first.
        ier_write(2'b10);
        frame(16, 24'h112200, got);
        st_read(rd);
        check("tc3_status_lit", rd, 32'h15);
`ifdef SPI_TGT_IRQ_EN
        check("tc3_irq_lit", {31'd0, interrupt_spi}, 32'd1);
`else
        check("tc3_irq_lit", {31'd0, interrupt_spi}, 32'd0);
`endif
        rx_read(rd);
        check("tc3_rx_lit", rd, 32'h11);
        st_w1c(32'h14);
        ier_write(2'b00);

        // Aborted frame after 5 bits, then a clean frame.
        frame(5, 24'hF80000, got);
        st_read(rd);
        check("tc4_status_lit", rd, 32'h10);
        tx_write(8'h5A);
        frame(8, 24'hC30000, got);
        check("tc4_miso_lit", {24'd0, got}, 32'h5A);
        rx_read(rd);
        check("tc4_rx_lit", rd, 32'hC3);

        // Out-of-range address: error, zero data, no side effect.
        apb(1'b0, 32'h10, 32'h0, rd, err);
        check("tc5_err_rd", {31'd0, err}, 32'd1);
        check("tc5_prdata", rd, 32'd0);
        apb(1'b1, 32'h10, 32'h77, rd, err);
        check("tc5_err_wr", {31'd0, err}, 32'd1);
        apb(1'b1, 32'h18, 32'h14, rd, err);
        check("tc5_err_w1c", {31'd0, err}, 32'd1);
        settle();
        st_read(rd);

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: tx_write(8'($urandom));
                1: frame(int'($urandom_range(1, 24)), 24'($urandom), got);
                2: rx_read(rd);
                3: st_read(rd);
                4: st_w1c(32'($urandom_range(0, 31)));
                default: ier_write(2'($urandom_range(0, 3)));
            endcase
        end

        // Reset in the middle of a frame.
        ier_write(2'b11);
        tx_write(8'h81);
        settled = 1'b0;
        @(negedge PCLK);
        cs_spi = 1'b0;
        repeat (8) @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            mosi_spi = i[0];
            repeat (HALF) @(negedge PCLK);
            sclk_spi = 1'b1;
            repeat (HALF) @(negedge PCLK);
            sclk_spi = 1'b0;
        end
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("mrst_oe", {31'd0, miso_oe}, 32'd0);
        check("mrst_miso", {31'd0, miso_spi}, 32'd0);
        check("mrst_irq", {31'd0, interrupt_spi}, 32'd0);
        check("mrst_prdata", PRDATA, 32'd0);
        check("mrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        m_reset();
        repeat (3) @(negedge PCLK);
        cs_spi = 1'b1;
        PRESETn = 1'b1;
        repeat (6) @(negedge PCLK);
        settle();
        st_read(rd);
        check("mrst_status_lit", rd, 32'h0);
        ier_write(2'b01);
        frame(8, 24'h960000, got);
        check("mrst_miso_lit", {24'd0, got}, 32'hFF);
        rx_read(rd);
        check("mrst_rx_lit", rd, 32'h96);

        settled = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target_apb.md
# spi_target_apb

APB-attached SPI target (slave) peripheral that acts as the far end of the codebase's APB SPI master link. It receives `sclk_spi`, `cs_spi` and `mosi_spi` from an external SPI master and drives `miso_spi`. Everything runs in the PCLK domain: SPI inputs are oversampled through synchronizers. The CPU loads transmit bytes, reads received bytes and takes an interrupt through a zero-wait APB3 register interface.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `sclk_spi`, `cs_spi`, `mosi_spi` (legal values 2–3).

Ports. One clock; reset is asynchronous and active-low.
- `PCLK` in 1: system clock.
- `PRESETn` in 1: asynchronous active-low reset.
- `PADDR` in 32: byte address; bits [3:2] select the register.
- `PSEL`, `PENABLE`, `PWRITE` in 1 each: APB3 control.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied 1.
- `PSLVERR` out 1: error response.
- `sclk_spi` in 1: SPI clock from master. Mode 0 (CPOL=0, CPHA=0).
- `cs_spi` in 1: chip select, active low.
- `mosi_spi` in 1: master-out data. MSB first.
- `miso_spi` out 1: target-out data.
- `miso_oe` out 1: output enable for the external tri-state buffer. It is 1 while cs is active.
- `interrupt_spi` out 1: level interrupt.

## Operation
Registers (offset, access):
- 0x0 TXDATA (W): bits [7:0] go into the TX holding register and TXFULL is set. Writing while TXFULL=1 overwrites the held byte with no error. Reads return 0.
- 0x4 RXDATA (R): returns `{24'b0, rx_data}` and clears RXAVAIL.
- 0x8 STATUS (R/W1C):
  - bit0 RXAVAIL, bit1 TXFULL, bit2 OVERRUN, bit3 BUSY (synced cs low), bit4 UNDERRUN.
  - Writing 1 clears bits 2 and 4. Other bits are read-only.
- 0xC IER (R/W):
  - bit0 enables the RXAVAIL interrupt.
  - bit1 enables the OVERRUN|UNDERRUN interrupt.
- Any access with `PADDR[11:4]` ≠ 0 returns `PSLVERR`=1 in the access phase, `PRDATA`=0, and has no side effect.

SPI state machine:
- **IDLE → SHIFT** on synced cs falling edge.
  - Load `tx_shift` from the holding register and clear TXFULL.
  - If TXFULL was 0, load 0xFF and set UNDERRUN instead.
  - Set `bit_cnt`=0 and `miso_oe`=1; `miso_spi` drives `tx_shift[7]`.
- **SHIFT, sclk rising:** shift `mosi` into `rx_shift` and increment `bit_cnt`.
  - At count 8, the byte is complete.
  - If RXAVAIL=0: `rx_data` ← the full byte and RXAVAIL is set.
  - If RXAVAIL=1: OVERRUN is set, the new byte is dropped and `rx_data` is kept.
  - `bit_cnt` wraps to 0.
- **SHIFT, sclk falling:**
  - If `bit_cnt`≠0: shift `tx_shift` left and present the next bit.
  - If `bit_cnt`=0 (byte boundary): reload `tx_shift` from the holding register under the same TXFULL/UNDERRUN rule as the IDLE→SHIFT load.
- **SHIFT → IDLE** on synced cs rising edge.
  - A partial RX byte is discarded.
  - `bit_cnt`=0, `miso_oe`=0, `miso_spi`=0.
- `interrupt_spi` = `(IER[0]&RXAVAIL) | (IER[1]&(OVERRUN|UNDERRUN))`, registered.

## Timing
- Reset values:
  - `PRDATA`=0, `PSLVERR`=0, `PREADY`=1.
  - `miso_spi`=0, `miso_oe`=0, `interrupt_spi`=0.
  - All registers 0; FSM in IDLE.
- APB:
  - Zero wait states.
  - `PRDATA` and `PSLVERR` are combinational from registers during the access phase (`PSEL&PENABLE`) and 0 otherwise.
  - All side effects (write, RX pop, W1C) occur on the PCLK edge that ends the access phase.
- SPI latency:
  - SPI input edge to internal action is `SYNC_STAGES`+1 PCLK cycles.
  - `miso_spi` updates `SYNC_STAGES`+2 cycles after the sclk falling edge.
  - This requires f_PCLK ≥ 8·f_sclk and cs-low-to-first-sclk-rise ≥ 6 PCLK.
- Byte completion sets RXAVAIL 1 cycle after the detected 8th rising edge; `interrupt_spi` follows 1 cycle later.
- Simultaneous events:
  - RXDATA read and byte completion in the same cycle: the read returns the old byte; the new byte is stored and RXAVAIL stays 1, with no overrun.
  - TXDATA write and a TX load in the same cycle: the load takes the pre-write holding contents (0xFF plus UNDERRUN if empty); the written byte is held and TXFULL=1.
  - W1C clear and a new error event in the same cycle: the set wins.
- Reset asserted mid-frame: immediate return to reset values. The first post-reset frame starts only on a new cs falling edge.

## Configuration
- `SPI_TGT_IRQ_EN`:
  - Defined: IER and `interrupt_spi` logic are present as specified.
  - Undefined: IER reads 0 and ignores writes; `interrupt_spi` is tied 0. Status flags are unaffected.

## Test plan
- Write TXDATA=0xA5; master sends 0x3C in one frame → master receives 0xA5; RXDATA reads 0x3C; RXAVAIL 1→0 after the read; TXFULL=0.
- Frame with TXFULL=0 → master receives 0xFF; STATUS bit4=1; W1C 0x10 clears it.
- Two bytes (0x11, 0x22) received without an intervening read → RXDATA=0x11, OVERRUN=1, `interrupt_spi`=1 with IER=0x2.
- cs deasserted after 5 bits → no RXAVAIL; `miso_oe`=0 within `SYNC_STAGES`+2 cycles; the next full frame receives correctly.
- Read at PADDR=0x10 → `PSLVERR`=1, `PRDATA`=0, no state change. `PRESETn` pulsed mid-frame → all outputs return to reset values.
